// File: rtl/servo_pwm_multi.sv
// -----------------------------------------------------------------------------
// servo_pwm_multi
//
// Multi-channel servo PWM generator. All channels share one free-running frame
// counter; each channel drives a pulse whose high time follows a per-channel
// target. Targets are clamped into [DUTY_MIN, DUTY_MAX] on write. The live
// duty ("cur") moves toward the target by at most STEP_MAX clocks per frame
// (STEP_MAX = 0 jumps straight to the target). Duty and enable changes are
// applied only on the last cycle of a frame, so a pulse is never cut short or
// stretched mid-frame.
//
// Parameters
//   CLK_FREQ_HZ  input clock frequency
//   PWM_FREQ_HZ  frame rate; PERIOD = CLK_FREQ_HZ / PWM_FREQ_HZ clocks
//   NUM_CH       channel count (1..16)
//   CNT_W        width of the frame counter and of all duty values
//   DUTY_MIN     lowest allowed high time, in clocks
//   DUTY_MAX     highest allowed high time, in clocks
//   STEP_MAX     largest duty change per frame, in clocks (0 = unlimited)
//
// Ports
//   clk           clock, sole domain
//   reset         synchronous, active-high reset
//   wr_en         one-cycle target write strobe
//   wr_ch         channel index for the write (indices >= NUM_CH are dropped)
//   wr_duty       requested high time in clocks (clamped on capture)
//   ch_enable     per-channel output enable level, sampled at frame end
//   pwm_sig       registered PWM outputs
//   period_start  registered one-cycle pulse in the first cycle of each frame
//   settled       per channel: live duty equals the target
//
// Write interface: wr_en is a plain strobe with no ready/backpressure. Every
// cycle with wr_en high and wr_ch < NUM_CH captures wr_duty into that
// channel's target; the last write before a frame end is the one applied.
// Reset has priority over a simultaneous write.
// -----------------------------------------------------------------------------
module servo_pwm_multi #(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int PWM_FREQ_HZ = 50,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DUTY_MIN    = 27000,
    parameter int DUTY_MAX    = 54000,
    parameter int STEP_MAX    = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_duty,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] pwm_sig,
    output logic              period_start,
    output logic [NUM_CH-1:0] settled
);

    localparam int PERIOD   = CLK_FREQ_HZ / PWM_FREQ_HZ;
    localparam int DUTY_MID = (DUTY_MIN + DUTY_MAX) / 2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(DUTY_MIN);
    localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0] MID_V    = CNT_W'(DUTY_MID);
    localparam logic [CNT_W-1:0] STEP_V   = CNT_W'(STEP_MAX);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // -------------------------------------------------------------------------
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("servo_pwm_multi: NUM_CH must be in 1..16");
    end
    if (PWM_FREQ_HZ < 1 || PERIOD < 1) begin : g_bad_period
        $error("servo_pwm_multi: PERIOD must be at least 1 clock");
    end
    if (DUTY_MIN < 0 || DUTY_MIN > DUTY_MAX || DUTY_MAX >= PERIOD) begin : g_bad_duty
        $error("servo_pwm_multi: need 0 <= DUTY_MIN <= DUTY_MAX < PERIOD");
    end
    if (STEP_MAX < 0) begin : g_bad_step
        $error("servo_pwm_multi: STEP_MAX must be non-negative");
    end
    // An int PERIOD is always below 2^31, so only narrower counters need a check.
    if (CNT_W < 31) begin : g_cnt_w_check
        if (PERIOD >= (1 << CNT_W)) begin : g_bad_cnt_w
            $error("servo_pwm_multi: PERIOD does not fit in CNT_W bits");
        end
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  target [NUM_CH];
    logic [CNT_W-1:0]  cur    [NUM_CH];
    logic [NUM_CH-1:0] en_latch;

    logic boundary;
    logic wr_valid;

    assign boundary = (cnt == LAST_CNT);

    // One extra bit so NUM_CH itself (e.g. 16) is representable in the compare.
    assign wr_valid = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH));

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] r;
        r = d;
        if (d < MIN_V) begin
            r = MIN_V;
        end else if (d > MAX_V) begin
            r = MAX_V;
        end
        return r;
    endfunction

    // Move c toward t by at most STEP_V. The larger operand is always the
    // minuend, so the difference never wraps.
    function automatic logic [CNT_W-1:0] slew_toward(input logic [CNT_W-1:0] c,
                                                     input logic [CNT_W-1:0] t);
        logic [CNT_W-1:0] r;
        r = t;
        if (STEP_MAX != 0) begin
            if (t >= c) begin
                if ((t - c) > STEP_V) begin
                    r = c + STEP_V;
                end
            end else begin
                if ((c - t) > STEP_V) begin
                    r = c - STEP_V;
                end
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Frame counter, duty/enable update at frame end, registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            period_start <= 1'b0;
            pwm_sig      <= '0;
            en_latch     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                target[i] <= MID_V;
                cur[i]    <= MID_V;
            end
        end else begin
            cnt <= boundary ? '0 : cnt + CNT_W'(1);

            // Registered from cnt==0, so it lines up with the first pwm_sig
            // cycle of the frame (pwm_sig also lags cnt by one cycle).
            period_start <= (cnt == '0);

            for (int i = 0; i < NUM_CH; i++) begin
                pwm_sig[i] <= en_latch[i] && (cnt < cur[i]);
            end

            // cur/en_latch change only here, so the compare above always sees
            // a value that is stable for the whole frame. A write landing in
            // this same cycle updates target after cur has sampled the old one.
            if (boundary) begin
                en_latch <= ch_enable;
                for (int i = 0; i < NUM_CH; i++) begin
                    cur[i] <= slew_toward(cur[i], target[i]);
                end
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_valid && (wr_ch == CH_W'(i))) begin
                    target[i] <= clamp_duty(wr_duty);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Settled flags
    // -------------------------------------------------------------------------
    always_comb begin
        settled = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            settled[i] = (cur[i] == target[i]);
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_multi
//
// Two instances share the clock and reset:
//   dut_a : NUM_CH=2, STEP_MAX=3  (slew-limited)
//   dut_b : NUM_CH=3, STEP_MAX=0  (direct jump; 2-bit wr_ch so index 3 is out
//           of range)
// Both use PERIOD=100, DUTY_MIN=10, DUTY_MAX=20 (mid = 15).
// A frame is walked from its period_start cycle; sample offset i sits at cnt
// value (i+1) % 100, so cnt==5 is offset 4 and cnt==99 is offset 98.
// -----------------------------------------------------------------------------
module tb_servo_pwm_multi;

    localparam int CNT_W = 32;
    localparam int PER   = 100;

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- dut_a
    logic             wr_en_a;
    logic [0:0]       wr_ch_a;
    logic [CNT_W-1:0] wr_duty_a;
    logic [1:0]       ch_enable_a;
    logic [1:0]       pwm_a;
    logic             ps_a;
    logic [1:0]       settled_a;

    servo_pwm_multi #(
        .CLK_FREQ_HZ(1000), .PWM_FREQ_HZ(10), .NUM_CH(2), .CNT_W(CNT_W),
        .DUTY_MIN(10), .DUTY_MAX(20), .STEP_MAX(3)
    ) dut_a (
        .clk(clk), .reset(reset),
        .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_duty(wr_duty_a),
        .ch_enable(ch_enable_a),
        .pwm_sig(pwm_a), .period_start(ps_a), .settled(settled_a)
    );

    // ---------------------------------------------------------------- dut_b
    logic             wr_en_b;
    logic [1:0]       wr_ch_b;
    logic [CNT_W-1:0] wr_duty_b;
    logic [2:0]       ch_enable_b;
    logic [2:0]       pwm_b;
    logic             ps_b;
    logic [2:0]       settled_b;

    servo_pwm_multi #(
        .CLK_FREQ_HZ(1000), .PWM_FREQ_HZ(10), .NUM_CH(3), .CNT_W(CNT_W),
        .DUTY_MIN(10), .DUTY_MAX(20), .STEP_MAX(0)
    ) dut_b (
        .clk(clk), .reset(reset),
        .wr_en(wr_en_b), .wr_ch(wr_ch_b), .wr_duty(wr_duty_b),
        .ch_enable(ch_enable_b),
        .pwm_sig(pwm_b), .period_start(ps_b), .settled(settled_b)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_cmp;
    int n_bad;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver
    // Walks one full frame starting on a negedge where period_start is high,
    // applies optional writes/enable changes at given offsets, measures high
    // times and ends on the next frame's first negedge.
    task automatic run_frame(input string tag,
                             input int ea0, input int ea1, input int eb0, input int eb1,
                             input logic [1:0] es_a, input logic [2:0] es_b,
                             input int wa_off, input int wa_ch, input int wa_duty,
                             input int wb_off, input int wb_ch, input int wb_duty,
                             input int en_off, input logic [1:0] en_val);
        int w_a0, w_a1, w_b0, w_b1, ps_cnt;
        w_a0 = 0; w_a1 = 0; w_b0 = 0; w_b1 = 0; ps_cnt = 0;
        exp_q.push_back(8'(ea0));
        exp_q.push_back(8'(ea1));
        exp_q.push_back(8'(eb0));
        exp_q.push_back(8'(eb1));

        chk({tag, "_ps_start_a"}, 32'(ps_a), 32'd1);
        chk({tag, "_ps_start_b"}, 32'(ps_b), 32'd1);
        chk({tag, "_settled_a"}, 32'(settled_a), 32'(es_a));
        chk({tag, "_settled_b"}, 32'(settled_b), 32'(es_b));

        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge clk);
            if (pwm_a[0]) w_a0++;
            if (pwm_a[1]) w_a1++;
            if (pwm_b[0]) w_b0++;
            if (pwm_b[1]) w_b1++;
            if (ps_a) ps_cnt++;
            wr_en_a = 1'b0;
            wr_en_b = 1'b0;
            if (i == wa_off) begin
                wr_en_a = 1'b1; wr_ch_a = 1'(wa_ch); wr_duty_a = CNT_W'(wa_duty);
            end
            if (i == wb_off) begin
                wr_en_b = 1'b1; wr_ch_b = 2'(wb_ch); wr_duty_b = CNT_W'(wb_duty);
            end
            if (i == en_off) ch_enable_a = en_val;
        end
        @(negedge clk);

        chk({tag, "_ps_per_frame"}, 32'(ps_cnt), 32'd1);
        chk({tag, "_width_a0"}, 32'(w_a0), 32'(exp_q.pop_front()));
        chk({tag, "_width_a1"}, 32'(w_a1), 32'(exp_q.pop_front()));
        chk({tag, "_width_b0"}, 32'(w_b0), 32'(exp_q.pop_front()));
        chk({tag, "_width_b1"}, 32'(w_b1), 32'(exp_q.pop_front()));
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        wr_en_a = 1'b0; wr_ch_a = '0; wr_duty_a = '0; ch_enable_a = '0;
        wr_en_b = 1'b0; wr_ch_b = '0; wr_duty_b = '0; ch_enable_b = '0;

        // Reset values; a write during reset must lose to reset.
        @(negedge clk);
        wr_en_a = 1'b1; wr_ch_a = 1'b0; wr_duty_a = 32'd12;
        @(negedge clk);
        wr_en_a = 1'b0;
        @(negedge clk);
        chk("rst_pwm_a", 32'(pwm_a), 32'd0);
        chk("rst_pwm_b", 32'(pwm_b), 32'd0);
        chk("rst_ps_a", 32'(ps_a), 32'd0);
        chk("rst_settled_a", 32'(settled_a), 32'd3);
        chk("rst_settled_b", 32'(settled_b), 32'd7);

        ch_enable_a = 2'b11;
        ch_enable_b = 3'b111;
        reset = 1'b0;
        @(negedge clk);

        // Frame 1: enable latch still 0 from reset.
        run_frame("f1", 0, 0, 0, 0, 2'b11, 3'b111, -1, 0, 0, -1, 0, 0, -1, 2'b11);
        // Frame 2: mid duty 15; dut_b write to out-of-range channel 3.
        run_frame("f2", 15, 15, 15, 15, 2'b11, 3'b111, -1, 0, 0, 10, 3, 12, -1, 2'b11);
        // Frame 3: a ch0 <- 50 (clamps to 20); b ch0 <- 18.
        run_frame("f3", 15, 15, 15, 15, 2'b11, 3'b111, 10, 0, 50, 10, 0, 18, -1, 2'b11);
        run_frame("f4", 18, 15, 18, 15, 2'b10, 3'b111, -1, 0, 0, -1, 0, 0, -1, 2'b11);
        // Frame 5: a ch1 <- 0 in the cnt==99 cycle (clamps to 10).
        run_frame("f5", 20, 15, 18, 15, 2'b11, 3'b111, 98, 1, 0, -1, 0, 0, -1, 2'b11);
        run_frame("f6", 20, 15, 18, 15, 2'b01, 3'b111, -1, 0, 0, -1, 0, 0, -1, 2'b11);
        run_frame("f7", 20, 12, 18, 15, 2'b01, 3'b111, -1, 0, 0, -1, 0, 0, -1, 2'b11);
        // Frame 8: drop ch0 enable at cnt==5; pulse still full width.
        run_frame("f8", 20, 10, 18, 15, 2'b11, 3'b111, -1, 0, 0, -1, 0, 0, 4, 2'b10);
        // Frame 9: ch0 dark; re-enable mid-frame.
        run_frame("f9", 0, 10, 18, 15, 2'b11, 3'b111, -1, 0, 0, -1, 0, 0, 50, 2'b11);
        run_frame("f10", 20, 10, 18, 15, 2'b11, 3'b111, -1, 0, 0, -1, 0, 0, -1, 2'b11);

        // Reset at cnt==7, in the middle of ch0's pulse.
        repeat (6) @(negedge clk);
        chk("pre_rst_pwm_a0", 32'(pwm_a[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pwm_a", 32'(pwm_a), 32'd0);
        chk("mid_rst_pwm_b", 32'(pwm_b), 32'd0);
        chk("mid_rst_ps_a", 32'(ps_a), 32'd0);
        @(negedge clk);
        chk("mid_rst_settled_a", 32'(settled_a), 32'd3);
        reset = 1'b0;
        @(negedge clk);
        // Counter restarted at 0: period_start on the first cycle after release.
        run_frame("r1", 0, 0, 0, 0, 2'b11, 3'b111, -1, 0, 0, -1, 0, 0, -1, 2'b11);
        run_frame("r2", 15, 15, 15, 15, 2'b11, 3'b111, -1, 0, 0, -1, 0, 0, -1, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
